ex_unit_bank: RTL

Bank of `size` single-issue integer execute units, one per reservation-station slot. Each unit watches its slot's `rs_data[i]` and waits until the entry is valid with both operands resolved. It then captures the operands and computes the ALU, compare, jump or branch result. Finally it drives a one-cycle `alu_data_bus[i]` result pulse. That pulse retires the slot in the reservation station and forwards the result to the ROB and waiting stations.

---
 rtl/ex_unit_bank.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/ex_unit_bank.sv
// Bank of independent single-issue execute units, one per reservation-station
// slot. Each unit captures a ready entry, computes its result for one cycle,
// then presents a one-cycle result pulse on its own bus lane.

package ex_unit_pkg;
    localparam int EX_UNITS    = 4;
    localparam int ROB_ID_SIZE = 5;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_REG   = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    typedef struct packed {
        logic                   valid;
        logic                   r1;
        logic                   r2;
        logic [31:0]            rs1_v;
        logic [31:0]            rs2_v;
        logic [6:0]             opcode;
        logic [2:0]             funct3;
        logic [2:0]             aluop;
        logic [2:0]             cmpop;
        logic                   alu_cmp;
        logic [ROB_ID_SIZE-1:0] rob_id_dest;
        logic [31:0]            pc;
        logic [31:0]            b_imm;
    } rs_d;

    typedef struct packed {
        logic                   ready;
        logic [ROB_ID_SIZE-1:0] rob_id;
        logic [31:0]            rd_data;
        logic                   br_en;
        logic [31:0]            br_target;
    } ex_data_bus_t;
endpackage

module ex_unit_bank
    import ex_unit_pkg::*;
#(
    parameter int size     = EX_UNITS,
    parameter int rob_size = ROB_ID_SIZE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         branch_mispredict,
    input  rs_d          rs_data      [size],
    output ex_data_bus_t alu_data_bus [size]
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Operand register: everything the result depends on, frozen at capture.
    typedef struct packed {
        logic [31:0]         rs1;
        logic [31:0]         rs2;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [2:0]          aluop;
        logic [2:0]          cmpop;
        logic                alu_cmp;
        logic [rob_size-1:0] rob_id;
        logic [31:0]         pc;
        logic [31:0]         b_imm;
    } op_t;

    genvar gi;
    generate
        for (gi = 0; gi < size; gi++) begin : g_unit
            logic [1:0]   state_q, state_d;
            op_t          op_q, op_d;
            ex_data_bus_t bus_q, bus_d;
            logic         capture;
            logic [31:0]  alu_res;
            logic         cmp_res;
            logic [31:0]  sum_res;
            logic         unused_funct3;

            // funct3 is carried for debug visibility only; ops are pre-decoded.
            assign unused_funct3 = ^op_q.funct3;

            assign capture = (state_q == IDLE) && rs_data[gi].valid
                             && rs_data[gi].r1 && rs_data[gi].r2;
            assign sum_res = op_q.rs1 + op_q.rs2;

            // ALU datapath on the captured operands.
            always_comb begin
                alu_res = '0;
                case (op_q.aluop)
                    3'b000:  alu_res = op_q.rs1 + op_q.rs2;
                    3'b001:  alu_res = op_q.rs1 << op_q.rs2[4:0];
                    3'b010:  alu_res = $unsigned($signed(op_q.rs1) >>> op_q.rs2[4:0]);
                    3'b011:  alu_res = op_q.rs1 - op_q.rs2;
                    3'b100:  alu_res = op_q.rs1 ^ op_q.rs2;
                    3'b101:  alu_res = op_q.rs1 >> op_q.rs2[4:0];
                    3'b110:  alu_res = op_q.rs1 | op_q.rs2;
                    default: alu_res = op_q.rs1 & op_q.rs2;
                endcase
            end

            // Comparator shared by set-less-than and conditional branches.
            always_comb begin
                cmp_res = 1'b0;
                case (op_q.cmpop)
                    3'b000:  cmp_res = (op_q.rs1 == op_q.rs2);
                    3'b001:  cmp_res = (op_q.rs1 != op_q.rs2);
                    3'b100:  cmp_res = ($signed(op_q.rs1) <  $signed(op_q.rs2));
                    3'b101:  cmp_res = ($signed(op_q.rs1) >= $signed(op_q.rs2));
                    3'b110:  cmp_res = (op_q.rs1 <  op_q.rs2);
                    3'b111:  cmp_res = (op_q.rs1 >= op_q.rs2);
                    default: cmp_res = 1'b0;
                endcase
            end

            // Next state: capture in IDLE, produce result in EXEC, drop pulse in DONE.
            always_comb begin
                state_d = state_q;
                op_d    = op_q;
                bus_d   = bus_q;
                case (state_q)
                    IDLE: begin
                        if (capture) begin
                            op_d.rs1     = rs_data[gi].rs1_v;
                            op_d.rs2     = rs_data[gi].rs2_v;
                            op_d.opcode  = rs_data[gi].opcode;
                            op_d.funct3  = rs_data[gi].funct3;
                            op_d.aluop   = rs_data[gi].aluop;
                            op_d.cmpop   = rs_data[gi].cmpop;
                            op_d.alu_cmp = rs_data[gi].alu_cmp;
                            op_d.rob_id  = rs_data[gi].rob_id_dest;
                            op_d.pc      = rs_data[gi].pc;
                            op_d.b_imm   = rs_data[gi].b_imm;
                            state_d      = EXEC;
                        end
                    end
                    EXEC: begin
                        bus_d.ready     = 1'b1;
                        bus_d.rob_id    = op_q.rob_id;
                        bus_d.rd_data   = '0;
                        bus_d.br_en     = 1'b0;
                        bus_d.br_target = '0;
                        case (op_q.opcode)
                            OP_LUI, OP_AUIPC: bus_d.rd_data = alu_res;
                            OP_REG, OP_IMM:
                                bus_d.rd_data = op_q.alu_cmp ? {31'b0, cmp_res} : alu_res;
                            OP_JAL: begin
                                bus_d.rd_data   = op_q.pc + 32'd4;
                                bus_d.br_en     = 1'b1;
                                bus_d.br_target = sum_res;
                            end
                            OP_JALR: begin
                                bus_d.rd_data   = op_q.pc + 32'd4;
                                bus_d.br_en     = 1'b1;
                                bus_d.br_target = sum_res & ~32'd1;
                            end
                            OP_BR: begin
                                bus_d.br_en     = cmp_res;
                                bus_d.br_target = cmp_res ? (op_q.pc + op_q.b_imm)
                                                          : (op_q.pc + 32'd4);
                            end
                            default: ;
                        endcase
                        state_d = DONE;
                    end
                    DONE: begin
                        bus_d.ready = 1'b0;
                        state_d     = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
                // Flush: drop any pending result and block capture this edge.
                if (branch_mispredict) begin
                    state_d     = IDLE;
                    op_d        = op_q;
                    bus_d       = bus_q;
                    bus_d.ready = 1'b0;
                end
            end

            // State, operand and result registers.
            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= IDLE;
                    op_q    <= '0;
                    bus_q   <= '0;
                end else begin
                    state_q <= state_d;
                    op_q    <= op_d;
                    bus_q   <= bus_d;
                end
            end

            assign alu_data_bus[gi] = bus_q;
        end
    endgenerate

endmodule
